// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
package counter_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Number of bits needed to encode 'value' distinct states (at least 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((64'(1) << bits) < 64'(value)) begin
      bits = bits + 1;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/param_updown_counter.sv
// Parametrised loadable up/down counter with configurable modulus,
// wrap/saturate mode, terminal-count flag and single-cycle wrap and
// out-of-range-load pulses.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // The top state is MODULUS-1; the load check is done one bit wider so a
  // full-range modulus (2**WIDTH) still compares correctly.
  localparam int                 MOD_BITS  = clog2(MODULUS);
  localparam logic [WIDTH-1:0]   MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]     MOD_EXT   = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || MOD_BITS > WIDTH) begin : g_badModulus
    $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_loadErr;

  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextWrap;
  logic             w_nextLoadErr;
  logic             w_loadTooBig;
  logic             w_atMax;
  logic             w_atZero;

  assign w_loadTooBig = ({1'b0, data} >= MOD_EXT);
  assign w_atMax      = (r_count == MAX_COUNT);
  assign w_atZero     = (r_count == '0);

  // Next-state selection: load beats count beats hold; flags default low.
  always_comb begin
    w_nextCount   = r_count;
    w_nextWrap    = 1'b0;
    w_nextLoadErr = 1'b0;
    if (ld) begin
      if (w_loadTooBig) begin
        w_nextCount   = MAX_COUNT;
        w_nextLoadErr = 1'b1;
      end else begin
        w_nextCount = data;
      end
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (!w_atMax) begin
          w_nextCount = r_count + WIDTH'(1);
        end else if (sat == MODE_WRAP) begin
          w_nextCount = '0;
          w_nextWrap  = 1'b1;
        end
      end else begin
        if (!w_atZero) begin
          w_nextCount = r_count - WIDTH'(1);
        end else if (sat == MODE_WRAP) begin
          w_nextCount = MAX_COUNT;
          w_nextWrap  = 1'b1;
        end
      end
    end
  end

  // Single register stage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_count   <= w_nextCount;
      r_wrap    <= w_nextWrap;
      r_loadErr <= w_nextLoadErr;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_loadErr;
  assign tc       = ((up_dn == CNT_UP) && w_atMax) || ((up_dn == CNT_DN) && w_atZero);

  // Saturate mode holds at the end stop; nothing else in the datapath needs it.
  logic w_satUnused;
  assign w_satUnused = (sat == MODE_SAT);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: two instances (modulus 10 and 16) share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_param_updown_counter;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] data;
  logic       en;
  logic       up_dn;
  logic       sat;

  logic [3:0] count10, count16;
  logic       tc10, tc16, wrap10, wrap16, loadErr10, loadErr16;

  int checkCount;
  int passCount;

  int modTab[2]  = '{10, 16};
  int mCount[2];
  int mWrap[2];
  int mErr[2];

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .ld(ld), .data(data), .en(en), .up_dn(up_dn),
    .sat(sat), .count(count10), .tc(tc10), .wrap(wrap10), .load_err(loadErr10)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .ld(ld), .data(data), .en(en), .up_dn(up_dn),
    .sat(sat), .count(count16), .tc(tc16), .wrap(wrap16), .load_err(loadErr16)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount = checkCount + 1;
    if (observed == expected) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model: one clock edge for the instance with modulus modTab[i].
  task automatic modelStep(input int i);
    int m;
    m = modTab[i];
    if (!rst) begin
      mCount[i] = 0; mWrap[i] = 0; mErr[i] = 0;
    end else if (ld) begin
      mWrap[i]  = 0;
      mErr[i]   = (int'(data) >= m) ? 1 : 0;
      mCount[i] = (int'(data) >= m) ? m - 1 : int'(data);
    end else if (en) begin
      mWrap[i] = 0;
      mErr[i]  = 0;
      if (up_dn) begin
        if (!sat || mCount[i] + 1 < m) begin
          mWrap[i]  = (mCount[i] + 1 == m) ? 1 : 0;
          mCount[i] = (mCount[i] + 1) % m;
        end
      end else begin
        if (!sat || mCount[i] > 0) begin
          mWrap[i]  = (mCount[i] == 0) ? 1 : 0;
          mCount[i] = (mCount[i] + m - 1) % m;
        end
      end
    end else begin
      mWrap[i] = 0;
      mErr[i]  = 0;
    end
  endtask

  function automatic int modelTc(input int i);
    return ((up_dn && mCount[i] == modTab[i] - 1) || (!up_dn && mCount[i] == 0)) ? 1 : 0;
  endfunction

  // Drive one cycle of inputs, check tc before the edge and state after it.
  task automatic applyStimulus(input logic iRst, input logic iLd, input int iData,
                               input logic iEn, input logic iUp, input logic iSat);
    rst = iRst; ld = iLd; data = 4'(iData); en = iEn; up_dn = iUp; sat = iSat;
    #1;
    checkOutput("tc10", int'(tc10), modelTc(0));
    checkOutput("tc16", int'(tc16), modelTc(1));
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput("count10", int'(count10), mCount[0]);
    checkOutput("wrap10", int'(wrap10), mWrap[0]);
    checkOutput("loadErr10", int'(loadErr10), mErr[0]);
    checkOutput("count16", int'(count16), mCount[1]);
    checkOutput("wrap16", int'(wrap16), mWrap[1]);
    checkOutput("loadErr16", int'(loadErr16), mErr[1]);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < 2; i++) begin
      mCount[i] = 0; mWrap[i] = 0; mErr[i] = 0;
    end
    rst = 1'b0; ld = 1'b0; data = 4'd0; en = 1'b0; up_dn = 1'b1; sat = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over simultaneous load and enable.
    applyStimulus(1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_count", int'(count10), 0);
    checkOutput("rst_flags", int'({wrap10, loadErr10}), 0);

    // Load 7, count up through the modulus-10 wrap.
    applyStimulus(1'b1, 1'b1, 7, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("plan_at9_tc", int'(tc10), 1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("plan_wrap_count", int'(count10), 0);
    checkOutput("plan_wrap_pulse", int'(wrap10), 1);

    // Load 1, saturating down-count sticks at zero.
    applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    checkOutput("plan_sat_count", int'(count10), 0);
    checkOutput("plan_sat_wrap", int'(wrap10), 0);
    checkOutput("plan_sat_tc", int'(tc10), 1);

    // Out-of-range load with enable: clamps to 9, no increment.
    applyStimulus(1'b1, 1'b1, 12, 1'b1, 1'b1, 1'b0);
    checkOutput("plan_ld12_count", int'(count10), 9);
    checkOutput("plan_ld12_err", int'(loadErr10), 1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("plan_ld12_errclr", int'(loadErr10), 0);

    // Enable gating and a direction flip.
    applyStimulus(1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("plan_en_count", int'(count10), 5);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("plan_flip_count", int'(count10), 4);

    // Full-range modulus: wrap 15->0 and 0->15.
    applyStimulus(1'b1, 1'b1, 15, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkOutput("plan16_up_count", int'(count16), 0);
    checkOutput("plan16_up_wrap", int'(wrap16), 1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("plan16_dn_count", int'(count16), 15);
    checkOutput("plan16_dn_wrap", int'(wrap16), 1);

    // Randomised traffic; occasional reset and load, enable mostly on.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 31) != 0),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous loadable up/down counter; the next generation of the team's 4-bit loadable up counter.
- Adds configurable width and modulus, count direction, count enable, wrap/saturate mode, terminal-count and wrap flags, and out-of-range load detection.
- Used as a general event, timer or address counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, number of count states; count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; violation is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge).
- ld  input  1  load request.
- data  input  WIDTH  load value.
- en  input  1  count enable.
- up_dn  input  1  direction: 1=up, 0=down.
- sat  input  1  mode: 1=saturate, 0=wrap.
- count  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from count and up_dn).
- wrap  output  1  registered one-cycle pulse after a wrap.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.

Behaviour:
- All state updates on the rising clk edge. Priority per edge: rst=0 > ld=1 > en=1 > hold.
- Reset (rst=0): count=0, wrap=0, load_err=0. Reset wins over a simultaneous ld or en.
- Load (ld=1):
  - data < MODULUS: count<=data, load_err<=0.
  - data >= MODULUS: count<=MODULUS-1, load_err<=1.
  - en is ignored that cycle and wrap<=0.
  - Latency: 1 cycle; new count is visible after the edge.
- Count (en=1, ld=0):
  - Up, count<MODULUS-1: count+1.
  - Up, count==MODULUS-1: wrap mode gives 0 with wrap<=1; saturate mode holds with wrap<=0.
  - Down, count>0: count-1.
  - Down, count==0: wrap mode gives MODULUS-1 with wrap<=1; saturate mode holds with wrap<=0.
- Hold (en=0, ld=0): count unchanged; wrap<=0, load_err<=0.
- wrap and load_err are single-cycle pulses. They deassert on the next edge unless re-triggered.
- tc = (up_dn & count==MODULUS-1) | (~up_dn & count==0). tc is independent of en and sat.
- Direction or mode changes take effect on the same edge; there is no pipeline.
- Arithmetic is done in WIDTH bits, with explicit modulus compare. There is no reliance on natural 2**WIDTH overflow, except that MODULUS==2**WIDTH must still wrap correctly.
- Reset mid-count discards any pending load or count; flags clear.

Decomposition:
- Shared package counter_pkg:
  - localparams CNT_UP=1'b1, CNT_DN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - Function clog2 for derived widths.
- No sub-module. The next-count logic is a single combinational block feeding one register stage.

Test Plan:
- WIDTH=4, MODULUS=10: rst=0 for one edge with ld=1,en=1 -> count=0, wrap=0, load_err=0.
- Load data=7, then up-count en=1 wrap mode for 3 edges -> count 8,9,0. wrap=1 only in the cycle showing 0; tc=1 while count=9.
- Load data=1, down-count, sat=1, 3 edges -> count 0,0,0; wrap stays 0; tc=1 at count 0.
- Load data=12 (>=MODULUS) -> count=9, load_err=1 for one cycle, then 0. Same edge with en=1 -> count not incremented.
- Count up with en toggling 1,0,1 from count=3 -> count 4,4,5. Flip up_dn=0 at count=5 -> next count 4.
- WIDTH=4, MODULUS=16: up-count wrap from 15 -> count 0, wrap=1. Down from 0 -> count 15, wrap=1.
